// File: rtl/ahb_gpio_bank.sv
// AHB-lite GPIO bank: NPORTS 8-bit ports with synchronised inputs, per-pin
// edge capture into write-one-to-clear status, and one masked interrupt per port.
module ahb_gpio_bank #(
    parameter int         NPORTS      = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] OEB_RESET   = 8'hFF
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    input  logic                HWRITE,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    input  logic [8*NPORTS-1:0] gpio_in,
    output logic [8*NPORTS-1:0] gpio_out,
    output logic [8*NPORTS-1:0] gpio_oeb,
    output logic [NPORTS-1:0]   port_irq
);

    localparam int         W        = 8 * NPORTS;
    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    localparam logic [2:0] OFF_OUT  = 3'd0;
    localparam logic [2:0] OFF_OEB  = 3'd1;
    localparam logic [2:0] OFF_IN   = 3'd2;
    localparam logic [2:0] OFF_IE   = 3'd3;
    localparam logic [2:0] OFF_POL  = 3'd4;
    localparam logic [2:0] OFF_STAT = 3'd5;
    localparam logic [2:0] OFF_SET  = 3'd6;
    localparam logic [2:0] OFF_CLR  = 3'd7;

    logic                          ap_valid_d, ap_valid_q;
    logic                          ap_write_d, ap_write_q;
    logic [8:0]                    ap_addr_d,  ap_addr_q;
    logic [W-1:0]                  out_d,  out_q;
    logic [W-1:0]                  oeb_d,  oeb_q;
    logic [W-1:0]                  ie_d,   ie_q;
    logic [W-1:0]                  pol_d,  pol_q;
    logic [W-1:0]                  stat_d, stat_q;
    logic [W-1:0]                  prev_d, prev_q;
    logic [SYNC_STAGES-1:0][W-1:0] sync_d, sync_q;
    logic [2:0]                    arm_cnt_d, arm_cnt_q;

    logic [3:0]        port_idx;
    logic [2:0]        reg_off;
    logic [NPORTS-1:0] port_hit;
    logic              wr_en;
    logic              rd_en;
    logic              armed;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic [W-1:0]      in_sync;
    logic [W-1:0]      edge_hit;
    logic [W-1:0]      w1c_mask;
    logic              unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:9], HADDR[1:0], HWDATA[31:8], HTRANS[0]};

    assign port_idx  = ap_addr_q[8:5];
    assign reg_off   = ap_addr_q[4:2];
    assign wr_en     = ap_valid_q & ap_write_q;
    assign rd_en     = ap_valid_q & ~ap_write_q;
    assign wdata     = HWDATA[7:0];
    assign in_sync   = sync_q[SYNC_STAGES-1];
    assign armed     = (arm_cnt_q == ARM_LAST);
    assign HREADYOUT = 1'b1;
    assign HRDATA    = {24'd0, rdata};
    assign gpio_out  = out_q;
    assign gpio_oeb  = oeb_q;

    always_comb begin
        ap_valid_d = HSEL & HREADY & HTRANS[1];
        ap_write_d = ap_valid_d ? HWRITE : ap_write_q;
        ap_addr_d  = ap_valid_d ? HADDR[8:0] : ap_addr_q;
        for (int p = 0; p < NPORTS; p++) begin
            port_hit[p] = (port_idx == 4'(p));
        end
    end

    always_comb begin
        out_d    = out_q;
        oeb_d    = oeb_q;
        ie_d     = ie_q;
        pol_d    = pol_q;
        w1c_mask = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (wr_en && port_hit[p]) begin
                case (reg_off)
                    OFF_OUT:  out_d[8*p +: 8]    = wdata;
                    OFF_OEB:  oeb_d[8*p +: 8]    = wdata;
                    OFF_IE:   ie_d[8*p +: 8]     = wdata;
                    OFF_POL:  pol_d[8*p +: 8]    = wdata;
                    OFF_STAT: w1c_mask[8*p +: 8] = wdata;
                    OFF_SET:  out_d[8*p +: 8]    = out_q[8*p +: 8] | wdata;
                    OFF_CLR:  out_d[8*p +: 8]    = out_q[8*p +: 8] & ~wdata;
                    default:  ;
                endcase
            end
        end
    end

    // A fresh edge beats a simultaneous W1C of the same bit.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_in};
        prev_d    = in_sync;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        edge_hit  = armed ? ((pol_q & in_sync & ~prev_q) | (~pol_q & ~in_sync & prev_q)) : '0;
        stat_d    = (stat_q & ~w1c_mask) | edge_hit;
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (rd_en && port_hit[p]) begin
                case (reg_off)
                    OFF_OUT:  rdata = out_q[8*p +: 8];
                    OFF_OEB:  rdata = oeb_q[8*p +: 8];
                    OFF_IN:   rdata = in_sync[8*p +: 8];
                    OFF_IE:   rdata = ie_q[8*p +: 8];
                    OFF_POL:  rdata = pol_q[8*p +: 8];
                    OFF_STAT: rdata = stat_q[8*p +: 8];
                    default:  rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            port_irq[p] = |(stat_q[8*p +: 8] & ie_q[8*p +: 8]);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_q <= 1'b0;
            ap_write_q <= 1'b0;
            ap_addr_q  <= '0;
            out_q      <= '0;
            oeb_q      <= {NPORTS{OEB_RESET}};
            ie_q       <= '0;
            pol_q      <= '0;
            stat_q     <= '0;
            prev_q     <= '0;
            sync_q     <= '0;
            arm_cnt_q  <= '0;
        end else begin
            ap_valid_q <= ap_valid_d;
            ap_write_q <= ap_write_d;
            ap_addr_q  <= ap_addr_d;
            out_q      <= out_d;
            oeb_q      <= oeb_d;
            ie_q       <= ie_d;
            pol_q      <= pol_d;
            stat_q     <= stat_d;
            prev_q     <= prev_d;
            sync_q     <= sync_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_gpio_bank.sv
// Scoreboard bench for ahb_gpio_bank: directed scenarios followed by random
// bus traffic and pin activity, checked against a register-level model.
module tb_ahb_gpio_bank;

    localparam int NPORTS      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int W           = 8 * NPORTS;

    logic          HCLK;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oeb;
    logic [NPORTS-1:0] port_irq;

    ahb_gpio_bank #(
        .NPORTS      (NPORTS),
        .SYNC_STAGES (SYNC_STAGES),
        .OEB_RESET   (8'hFF)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .port_irq  (port_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: one byte per register per port, plus the pin history.
    logic [7:0]   mOut  [NPORTS];
    logic [7:0]   mOeb  [NPORTS];
    logic [7:0]   mIe   [NPORTS];
    logic [7:0]   mPol  [NPORTS];
    logic [7:0]   mStat [NPORTS];
    logic [W-1:0] pinHist[$];
    int           edgesSinceReset;
    bit           dpValid;
    bit           dpWrite;
    logic [8:0]   dpAddr;
    logic [7:0]   expQ[$];
    bit           monitorOn = 1'b0;

    logic [7:0]   pendingData;
    bit           lastWasOurs;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        for (int p = 0; p < NPORTS; p++) begin
            mOut[p]  = 8'h00;
            mOeb[p]  = 8'hFF;
            mIe[p]   = 8'h00;
            mPol[p]  = 8'h00;
            mStat[p] = 8'h00;
        end
        pinHist.delete();
        repeat (SYNC_STAGES + 1) pinHist.push_back('0);
        edgesSinceReset = 0;
        dpValid = 1'b0;
        dpWrite = 1'b0;
        dpAddr  = '0;
        expQ.delete();
    endfunction

    // pinHist[j] holds the pad sample taken j edges ago; IN lags the pad by
    // SYNC_STAGES-1 edges, so IN is pinHist[SYNC_STAGES-1] right after an edge.
    function automatic logic [7:0] modelRead(input logic [8:0] a);
        int p   = int'(a[8:5]);
        int off = int'(a[4:2]);
        logic [W-1:0] inNow = pinHist[SYNC_STAGES-1];
        if (p >= NPORTS) return 8'h00;
        case (off)
            0:       return mOut[p];
            1:       return mOeb[p];
            2:       return inNow[8*p +: 8];
            3:       return mIe[p];
            4:       return mPol[p];
            5:       return mStat[p];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void modelStep();
        logic [W-1:0] inNow  = pinHist[SYNC_STAGES-1];
        logic [W-1:0] inPrev = pinHist[SYNC_STAGES];
        int  dpPort = int'(dpAddr[8:5]);
        int  dpOff  = int'(dpAddr[4:2]);
        bit  writeHit = dpValid && dpWrite && (dpPort < NPORTS);
        logic [7:0] wd = HWDATA[7:0];
        bit  armedNow = (edgesSinceReset >= SYNC_STAGES + 1);
        for (int p = 0; p < NPORTS; p++) begin
            for (int b = 0; b < 8; b++) begin
                bit changed  = (inNow[8*p+b] != inPrev[8*p+b]);
                bit edgeSeen = armedNow && changed && (inNow[8*p+b] == mPol[p][b]);
                bit clearReq = writeHit && (dpPort == p) && (dpOff == 5) && wd[b];
                if (edgeSeen)      mStat[p][b] = 1'b1;
                else if (clearReq) mStat[p][b] = 1'b0;
            end
        end
        if (writeHit) begin
            case (dpOff)
                0: mOut[dpPort] = wd;
                1: mOeb[dpPort] = wd;
                3: mIe[dpPort]  = wd;
                4: mPol[dpPort] = wd;
                6: mOut[dpPort] = mOut[dpPort] | wd;
                7: mOut[dpPort] = mOut[dpPort] & ~wd;
                default: ;
            endcase
        end
        pinHist.push_front(gpio_in);
        void'(pinHist.pop_back());
        if (edgesSinceReset < SYNC_STAGES + 1) edgesSinceReset++;
        dpValid = HSEL && HREADY && HTRANS[1];
        dpWrite = HWRITE;
        dpAddr  = HADDR[8:0];
        if (dpValid && !dpWrite) expQ.push_back(modelRead(dpAddr));
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) modelReset();
        else          modelStep();
    end

    function automatic logic [W-1:0] packBytes(input logic [7:0] arr [NPORTS]);
        logic [W-1:0] v;
        for (int p = 0; p < NPORTS; p++) v[8*p +: 8] = arr[p];
        return v;
    endfunction

    function automatic logic [NPORTS-1:0] expectedIrq();
        logic [NPORTS-1:0] v;
        for (int p = 0; p < NPORTS; p++) v[p] = |(mStat[p] & mIe[p]);
        return v;
    endfunction

    // Monitor: on every falling edge, pop the pending read expectation when a
    // read data phase is live, otherwise expect HRDATA idle at zero.
    always @(negedge HCLK) begin
        if (monitorOn) begin
            checkOutput("HREADYOUT", HREADYOUT, 1'b1);
            if (dpValid && !dpWrite) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL read queue: got empty queue, expected one pending read at %0t", $time);
                end else begin
                    checkOutput("HRDATA read", HRDATA, {24'd0, expQ.pop_front()});
                end
            end else begin
                checkOutput("HRDATA idle", HRDATA, 32'd0);
            end
            checkOutput("gpio_out", gpio_out, packBytes(mOut));
            checkOutput("gpio_oeb", gpio_oeb, packBytes(mOeb));
            checkOutput("port_irq", port_irq, expectedIrq());
        end
    end

    function automatic logic [31:0] regAddr(input int p, input int off);
        return 32'(p * 32 + off * 4);
    endfunction

    task automatic applyStimulus(input bit ready, input logic [1:0] trans, input bit write,
                                 input logic [31:0] addr, input logic [7:0] data);
        HSEL   = 1'b1;
        HREADY = ready;
        HTRANS = trans;
        HWRITE = write;
        HADDR  = addr;
        HWDATA = {24'($urandom()), pendingData};
        pendingData = write ? data : 8'($urandom());
        lastWasOurs = ready && trans[1];
        @(negedge HCLK);
    endtask

    task automatic applyIdle();
        HSEL   = 1'b0;
        HREADY = 1'b1;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = {24'($urandom()), pendingData};
        pendingData = 8'($urandom());
        lastWasOurs = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic wr(input int p, input int off, input logic [7:0] d);
        applyStimulus(1'b1, 2'b10, 1'b1, regAddr(p, off), d);
    endtask

    task automatic rd(input int p, input int off);
        applyStimulus(1'b1, 2'b10, 1'b0, regAddr(p, off), 8'h00);
    endtask

    initial begin
        HRESETn = 1'b1;
        HSEL = 1'b0; HADDR = '0; HWDATA = '0; HREADY = 1'b1;
        HWRITE = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
        gpio_in = '1;
        pendingData = 8'h00;
        lastWasOurs = 1'b0;
        modelReset();
        monitorOn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);

        // Pins high through reset must not leave status behind.
        repeat (10) applyIdle();
        for (int p = 0; p < NPORTS; p++) rd(p, 5);
        applyIdle();

        // OUT write, SET, CLR, then an immediate back-to-back readback.
        wr(2, 0, 8'hA5);
        wr(2, 6, 8'h0A);
        wr(2, 7, 8'h81);
        rd(2, 0);
        applyIdle();

        // Drop all pins (falling edges with POL=0) and clear the status.
        gpio_in = '0;
        repeat (SYNC_STAGES + 3) applyIdle();
        for (int p = 0; p < NPORTS; p++) wr(p, 5, 8'hFF);
        applyIdle();

        // Rising edge on port 0 pin 0 with the interrupt enabled.
        wr(0, 4, 8'h01);
        wr(0, 3, 8'h01);
        applyIdle();
        gpio_in[0] = 1'b1;
        repeat (SYNC_STAGES + 2) applyIdle();
        rd(0, 2);
        rd(0, 5);
        applyIdle();

        // W1C landing in the same cycle as a new edge: the edge must win.
        wr(0, 5, 8'h01);
        gpio_in[0] = 1'b0;
        repeat (SYNC_STAGES + 2) applyIdle();
        gpio_in[0] = 1'b1;
        repeat (SYNC_STAGES - 1) applyIdle();
        wr(0, 5, 8'h01);
        applyIdle();
        rd(0, 5);
        applyIdle();

        // Falling edge with IE off, then enable, then clear everything.
        gpio_in[25] = 1'b1;
        repeat (SYNC_STAGES + 2) applyIdle();
        gpio_in[25] = 1'b0;
        repeat (SYNC_STAGES + 2) applyIdle();
        rd(3, 5);
        wr(3, 3, 8'h02);
        applyIdle();
        applyIdle();
        wr(3, 5, 8'hFF);
        applyIdle();
        rd(3, 5);
        applyIdle();

        // Unmapped: missing port, write to IN, reads of SET/CLR.
        rd(NPORTS, 0);
        wr(NPORTS, 0, 8'hFF);
        wr(1, 2, 8'hFF);
        rd(1, 6);
        rd(1, 7);
        rd(1, 2);
        applyIdle();

        // Reset during a write data phase drops the write.
        wr(4, 0, 8'h55);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = {24'd0, 8'h55};
        #2 HRESETn = 1'b0;
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);
        repeat (SYNC_STAGES + 3) applyIdle();
        rd(4, 0);
        applyIdle();

        // Random traffic and pin activity.
        for (int n = 0; n < 800; n++) begin
            int sel = $urandom_range(0, 11);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < W; i++)
                    if ($urandom_range(0, 3) == 0) gpio_in[i] = ~gpio_in[i];
            end
            if (sel < 2) begin
                applyIdle();
            end else if (sel == 2 && !lastWasOurs) begin
                applyStimulus(1'b0, 2'b10, 1'($urandom_range(0, 1)), 32'($urandom()), 8'($urandom()));
            end else if (sel == 3) begin
                applyStimulus(1'b1, 2'b01, 1'($urandom_range(0, 1)), regAddr($urandom_range(0, NPORTS - 1), $urandom_range(0, 7)), 8'($urandom()));
            end else begin
                logic [31:0] a = 32'($urandom());
                if (sel == 4) a[8:0] = 9'($urandom_range(0, 511)) & 9'h1FC;
                else          a[8:0] = regAddr($urandom_range(0, NPORTS), $urandom_range(0, 7))[8:0];
                a[1:0] = 2'b00;
                applyStimulus(1'b1, (sel > 8) ? 2'b11 : 2'b10, 1'($urandom_range(0, 1)), a, 8'($urandom()));
            end
        end
        repeat (4) applyIdle();

        checkOutput("read queue drained", 128'(expQ.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
